// File: rtl/mdu_pkg.sv
// Shared types and op-decode helpers for the multiply/divide unit.
package mdu_pkg;

  typedef enum logic [1:0] {
    MULT  = 2'b00,
    MULTU = 2'b01,
    DIV   = 2'b10,
    DIVU  = 2'b11
  } mdu_op_t;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    PREP = 3'd1,
    RUN  = 3'd2,
    FIX  = 3'd3,
    DONE = 3'd4
  } mdu_state_t;

  function automatic logic is_div(input mdu_op_t op);
    return (op == DIV) || (op == DIVU);
  endfunction

  function automatic logic is_signed(input mdu_op_t op);
    return (op == MULT) || (op == DIV);
  endfunction

endpackage

// File: rtl/mdu_step.sv
// One radix-2 iteration on unsigned magnitudes.
// Multiply: {acc,q} holds the partial product, q[0] is the current multiplier bit.
// Divide:   acc is the partial remainder, q shifts the dividend out and the quotient in.
module mdu_step #(
  parameter int WIDTH = 32
) (
  input  logic             is_div,
  input  logic [WIDTH-1:0] acc_i,
  input  logic [WIDTH-1:0] q_i,
  input  logic [WIDTH-1:0] m_i,
  output logic [WIDTH-1:0] acc_o,
  output logic [WIDTH-1:0] q_o
);

  logic [WIDTH:0]   sum;
  logic [WIDTH:0]   rem_sh;
  logic             rem_ge;
  logic [WIDTH-1:0] rem_sub;

  // Shift-add and restoring shift-subtract, selected by is_div
  always_comb begin
    sum     = {1'b0, acc_i} + {1'b0, (q_i[0] ? m_i : '0)};
    rem_sh  = {acc_i, q_i[WIDTH-1]};
    rem_ge  = (rem_sh >= {1'b0, m_i});
    // When rem_ge holds the true difference is below the divisor, so it fits in WIDTH bits
    rem_sub = rem_sh[WIDTH-1:0] - m_i;
    acc_o   = sum[WIDTH:1];
    q_o     = {sum[0], q_i[WIDTH-1:1]};
    if (is_div) begin
      if (rem_ge) begin
        acc_o = rem_sub;
        q_o   = {q_i[WIDTH-2:0], 1'b1};
      end else begin
        acc_o = rem_sh[WIDTH-1:0];
        q_o   = {q_i[WIDTH-2:0], 1'b0};
      end
    end
  end

endmodule

// File: rtl/mult_div_unit.sv
// Sequential multiply/divide unit with architectural HI/LO registers.
//
// state | meaning
// ------+-----------------------------------------------------------
// IDLE  | waiting for start
// PREP  | take operand magnitudes, record result signs, trap div-by-0
// RUN   | WIDTH radix-2 iterations, one per cycle
// FIX   | apply result signs, write hi/lo on the edge into DONE
// DONE  | one-cycle done pulse; a new start may be accepted here
module mult_div_unit
  import mdu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             Clk,
  input  logic             reset,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] oper_A,
  input  logic [WIDTH-1:0] oper_B,
  input  logic             flush,
  output logic             busy,
  output logic             done,
  output logic             div_zero,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int CNT_W = $clog2(WIDTH) + 1;

  mdu_state_t       state_q, state_d;
  mdu_op_t          op_q, op_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] m_q, m_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0] q_q, q_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             neg_lo_q, neg_lo_d;
  logic             neg_hi_q, neg_hi_d;
  logic             dz_q, dz_d;
  logic [WIDTH-1:0] hi_q, hi_d;
  logic [WIDTH-1:0] lo_q, lo_d;

  logic [WIDTH-1:0]   step_acc;
  logic [WIDTH-1:0]   step_q;
  logic               a_neg, b_neg;
  logic [WIDTH-1:0]   a_mag, b_mag;
  logic [2*WIDTH-1:0] prod_raw, prod_fix;

  mdu_step #(.WIDTH(WIDTH)) u_step (
    .is_div (is_div(op_q)),
    .acc_i  (acc_q),
    .q_i    (q_q),
    .m_i    (m_q),
    .acc_o  (step_acc),
    .q_o    (step_q)
  );

  // Next-state and datapath control
  always_comb begin
    state_d  = state_q;
    op_d     = op_q;
    a_d      = a_q;
    b_d      = b_q;
    m_d      = m_q;
    acc_d    = acc_q;
    q_d      = q_q;
    cnt_d    = cnt_q;
    neg_lo_d = neg_lo_q;
    neg_hi_d = neg_hi_q;
    dz_d     = dz_q;
    hi_d     = hi_q;
    lo_d     = lo_q;

    a_neg    = is_signed(op_q) && a_q[WIDTH-1];
    b_neg    = is_signed(op_q) && b_q[WIDTH-1];
    a_mag    = a_neg ? -a_q : a_q;
    b_mag    = b_neg ? -b_q : b_q;
    prod_raw = {acc_q, q_q};
    prod_fix = neg_lo_q ? -prod_raw : prod_raw;

    unique case (state_q)
      IDLE, DONE: begin
        state_d = IDLE;
        // flush cancels a coinciding start
        if (start && !flush) begin
          op_d    = mdu_op_t'(op);
          a_d     = oper_A;
          b_d     = oper_B;
          dz_d    = 1'b0;
          state_d = PREP;
        end
      end
      PREP: begin
        if (flush) begin
          state_d = IDLE;
        end else if (is_div(op_q) && (b_q == '0)) begin
          dz_d    = 1'b1;
          state_d = DONE;
        end else begin
          q_d      = a_mag;
          m_d      = b_mag;
          acc_d    = '0;
          cnt_d    = CNT_W'(WIDTH);
          neg_lo_d = a_neg ^ b_neg;
          // remainder follows the dividend's sign
          neg_hi_d = a_neg;
          state_d  = RUN;
        end
      end
      RUN: begin
        if (flush) begin
          state_d = IDLE;
        end else begin
          acc_d = step_acc;
          q_d   = step_q;
          cnt_d = cnt_q - CNT_W'(1);
          if (cnt_q == CNT_W'(1)) state_d = FIX;
        end
      end
      FIX: begin
        if (flush) begin
          state_d = IDLE;
        end else begin
          if (is_div(op_q)) begin
            lo_d = neg_lo_q ? -q_q : q_q;
            hi_d = neg_hi_q ? -acc_q : acc_q;
          end else begin
            {hi_d, lo_d} = prod_fix;
          end
          state_d = DONE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers, synchronous active-low reset
  always_ff @(posedge Clk) begin
    if (!reset) begin
      state_q  <= IDLE;
      op_q     <= MULT;
      a_q      <= '0;
      b_q      <= '0;
      m_q      <= '0;
      acc_q    <= '0;
      q_q      <= '0;
      cnt_q    <= '0;
      neg_lo_q <= 1'b0;
      neg_hi_q <= 1'b0;
      dz_q     <= 1'b0;
      hi_q     <= '0;
      lo_q     <= '0;
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      a_q      <= a_d;
      b_q      <= b_d;
      m_q      <= m_d;
      acc_q    <= acc_d;
      q_q      <= q_d;
      cnt_q    <= cnt_d;
      neg_lo_q <= neg_lo_d;
      neg_hi_q <= neg_hi_d;
      dz_q     <= dz_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
    end
  end

  // Status outputs decoded from state
  always_comb begin
    busy     = (state_q == PREP) || (state_q == RUN) || (state_q == FIX);
    done     = (state_q == DONE);
    div_zero = (state_q == DONE) && dz_q;
    hi       = hi_q;
    lo       = lo_q;
  end

endmodule

// File: doc/mult_div_unit.md
Name: mult_div_unit

Overview:
Parametrised sequential multiply/divide unit with architectural HI/LO result registers. It is the successor to the fixed 32-bit multiplier in the multicycle MIPS datapath and adds signed/unsigned multiply, signed/unsigned divide, divide-by-zero flagging and pipeline flush. Control FSM drives start/flush and stalls on busy. ALUOut mux selects hi or lo for MFHI/MFLO.

Parameters:
WIDTH, 32, operand width; hi and lo are each WIDTH bits; must be >= 4.
CNT_W, $clog2(WIDTH)+1, iteration counter width (derived, not overridden).

Ports:
Clk  input  1  clock, all state updates on rising edge
reset  input  1  synchronous reset, active-low
start  input  1  begin operation; sampled only in IDLE or DONE
op  input  2  00 MULT, 01 MULTU, 10 DIV, 11 DIVU; sampled with start
oper_A  input  WIDTH  multiplicand/dividend; latched on accepted start
oper_B  input  WIDTH  multiplier/divisor; latched on accepted start
flush  input  1  abort in-flight operation (exception path)
busy  output  1  high in PREP, RUN, FIX
done  output  1  one-cycle pulse in DONE
div_zero  output  1  high with done when a DIV/DIVU divisor was 0
hi  output  WIDTH  MULT: product[2W-1:W]; DIV: remainder
lo  output  WIDTH  MULT: product[W-1:0]; DIV: quotient

Behaviour:
- Clock Clk. Reset is synchronous and active-low: reset=0 at a rising edge forces state=IDLE and hi=lo=0. busy, done and div_zero are all 0 after reset. Reset overrides flush and start.
- States: IDLE, PREP, RUN, FIX, DONE.
- IDLE: start=1 latches op, oper_A and oper_B, then moves to PREP. start=0 stays in IDLE.
- PREP:
  - For signed ops, take the magnitudes of the operands and record the result signs.
  - Product sign = sA xor sB. Remainder sign = sA.
  - For DIV/DIVU with oper_B=0, go to DONE and set div_zero=1. hi and lo are not written.
  - Otherwise clear the accumulator, load counter=WIDTH and go to RUN.
- RUN: one radix-2 step per cycle, exactly WIDTH cycles.
  - Multiply: shift-add.
  - Divide: restoring shift-subtract.
  - Counter decrements each cycle; at counter=1, go to FIX.
- FIX: negate the product, quotient or remainder as required by the recorded signs. Write hi/lo on the edge into DONE.
- DONE: done=1 for one cycle, then go to IDLE. start=1 in DONE is accepted (DONE->PREP), which allows back-to-back operations.
- Latency: an accepted start in cycle t gives done in cycle t+WIDTH+3 (t+35 for WIDTH=32). Divide-by-zero gives done in cycle t+2.
- start while busy=1 is ignored; no queuing.
- Latched operands are frozen; oper_A/oper_B changes after acceptance have no effect.
- flush=1 in PREP, RUN or FIX: state goes to IDLE on the next edge. hi/lo are retained, with no done and no div_zero. flush in IDLE or DONE has no effect, except that it cancels a coinciding start.
- Arithmetic rules:
  - MULT: full 2*WIDTH two's-complement product.
  - MULTU: unsigned product.
  - DIV: quotient truncates toward zero; remainder carries the dividend's sign.
  - DIV of most-negative by -1: lo=most-negative, hi=0, no flag.
- hi/lo change only on the edge into DONE after a successful operation, or on reset.

Decomposition:
- Package mdu_pkg holds:
  - mdu_op_t enum (MULT, MULTU, DIV, DIVU);
  - mdu_state_t enum (IDLE, PREP, RUN, FIX, DONE);
  - op-decode helper functions is_div() and is_signed().
- Sub-module mdu_step: a combinational single-iteration datapath for shift-add / shift-subtract, parametrised by WIDTH. It is instantiated once; the FSM, counter and hi/lo registers stay in mult_div_unit.

Test Plan:
- MULT oper_A=FFFFFFFD, oper_B=00000005, start at cycle t -> done exactly at t+35; hi=FFFFFFFF, lo=FFFFFFF1; busy high from t+1 to t+34.
- MULTU FFFFFFFF*FFFFFFFF -> hi=FFFFFFFE, lo=00000001. Back-to-back start in DONE with MULTU 0*5 -> hi=lo=0 at +35.
- DIV FFFFFFF9/00000002 -> lo=FFFFFFFD, hi=FFFFFFFF. DIVU 7/2 -> lo=3, hi=1. DIV 80000000/FFFFFFFF -> lo=80000000, hi=0, div_zero=0.
- DIVU 5/0 with prior hi=1, lo=3 -> done and div_zero at t+2; hi=1 and lo=3 unchanged; div_zero low the following cycle.
- Two mid-operation cases starting from a MULT at t:
  - start=1 again at t+5 -> ignored, and the result matches the original operands.
  - flush at t+10 -> busy=0 at t+11, no done pulse through t+40, hi/lo retained.
- reset=0 for one cycle during RUN with hi/lo nonzero -> next cycle busy=0, done=0, hi=lo=0. A start accepted right after reset completes normally.
